// File: rtl/instr_loader.sv
// Instruction memory loader: streams machine words into consecutive addresses from 0,
// holds the core in reset while loading and reports a mod-2**W checksum at the end.
module instr_loader #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic [D:0]   len,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         core_hold,
  output logic         busy,
  output logic         done,
  output logic         len_err,
  output logic [W-1:0] checksum
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [D:0] MAX_LEN  = {1'b1, {D{1'b0}}};
  localparam logic [D:0] ZERO_LEN = {(D+1){1'b0}};
  localparam logic [D:0] ONE_LEN  = {{D{1'b0}}, 1'b1};

  function automatic logic [W-1:0] csum_add(input logic [W-1:0] acc, input logic [W-1:0] word);
    return acc + word;
  endfunction

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [D:0]   len_r;
  logic [D:0]   count_r;
  logic [D:0]   count_inc_s;
  logic         hs_s;
  logic         start_ok_s;
  logic         start_bad_s;
  logic         wr_en_r;
  logic [D-1:0] wr_addr_r;
  logic [W-1:0] wr_data_r;
  logic         len_err_r;
  logic [W-1:0] checksum_r;

  assign hs_s        = in_valid & (state_r == ST_LOAD);
  assign count_inc_s = count_r + ONE_LEN;
  // Starts are only honoured in IDLE; a busy loader ignores them entirely.
  assign start_ok_s  = start & (state_r == ST_IDLE) & (len <= MAX_LEN);
  assign start_bad_s = start & (state_r == ST_IDLE) & (len > MAX_LEN);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          if (len == ZERO_LEN) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (hs_s && (count_inc_s == len_r)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Length, word count and running checksum
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      len_r      <= ZERO_LEN;
      count_r    <= ZERO_LEN;
      checksum_r <= {W{1'b0}};
    end else if (start_ok_s) begin
      len_r      <= len;
      count_r    <= ZERO_LEN;
      checksum_r <= {W{1'b0}};
    end else if (hs_s) begin
      count_r    <= count_inc_s;
      checksum_r <= csum_add(checksum_r, in_data);
    end else begin
      count_r    <= count_r;
      checksum_r <= checksum_r;
    end
  end

  // Memory write port: one cycle behind the handshake, address/data hold between writes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {D{1'b0}};
      wr_data_r <= {W{1'b0}};
    end else begin
      wr_en_r <= hs_s;
      if (hs_s) begin
        wr_addr_r <= count_r[D-1:0];
        wr_data_r <= in_data;
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

  // Oversized-length error pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= start_bad_s;
    end
  end

  assign in_ready  = (state_r == ST_LOAD);
  assign busy      = (state_r == ST_LOAD) | (state_r == ST_DONE);
  assign core_hold = (state_r == ST_LOAD) | (state_r == ST_DONE);
  assign done      = (state_r == ST_DONE);
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign len_err   = len_err_r;
  assign checksum  = checksum_r;

endmodule
